// File: rtl/block_noise_estimator.sv
// -----------------------------------------------------------------------------
// block_noise_estimator
//
// Streaming per-block noise estimator. Packed multi-channel pixels arrive over
// a valid/ready handshake. Each pixel is reduced to the floor of its channel
// mean. Every BLOCK_SIZE x BLOCK_SIZE block (raster ordered) yields its
// variance. The block variances of a frame are then reduced to one estimate.
//
// Build option:
//   BLOCK_NOISE_EST_MIN_EN  defined   -> the frame estimate is the minimum
//                                        block variance
//                           undefined -> the frame estimate is the mean block
//                                        variance (default)
//
// Parameters:
//   DATA_WIDTH  bits per channel sample
//   CHANNELS    channels packed per input word, channel 0 in the LSBs
//   BLOCK_SIZE  block edge, power of 2 in 2..16
//
// Ports:
//   clk                    rising-edge clock
//   rst                    asynchronous active-high reset
//   start_of_frame         one-cycle pulse: abort any frame in flight, arm a new one
//   blocks_per_frame_log2  log2 of blocks per frame, sampled at start_of_frame
//                          (clamped to 16)
//   s_data / s_valid / s_ready   pixel stream; a pixel is taken on s_valid && s_ready
//   block_var, block_var_valid   variance of the last completed block, one-cycle pulse
//   estimated_noise, estimated_noise_valid   frame estimate (held), one-cycle pulse
// -----------------------------------------------------------------------------
module block_noise_estimator #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 3,
  parameter int BLOCK_SIZE = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_of_frame,
  input  logic [4:0]                     blocks_per_frame_log2,
  input  logic [CHANNELS*DATA_WIDTH-1:0] s_data,
  input  logic                           s_valid,
  output logic                           s_ready,
  output logic [2*DATA_WIDTH-1:0]        block_var,
  output logic                           block_var_valid,
  output logic [2*DATA_WIDTH-1:0]        estimated_noise,
  output logic                           estimated_noise_valid
);

  localparam int LOG2_BS = $clog2(BLOCK_SIZE);
  localparam int LOG2_N  = 2 * LOG2_BS;                  // log2 of samples per block
  localparam int CSUM_W  = DATA_WIDTH + $clog2(CHANNELS) + 1;
  localparam int SUM_W   = DATA_WIDTH + LOG2_N;
  localparam int SQ_W    = 2 * DATA_WIDTH + LOG2_N;
  localparam int VAR_W   = 2 * DATA_WIDTH;
  localparam int BCNT_W  = 17;                           // holds up to 2^16 blocks

  typedef enum logic [1:0] {IDLE, ACCUM, FINAL} state_t;

  state_t                state, state_nxt;
  logic [SUM_W-1:0]      sum;
  logic [SQ_W-1:0]       sumsq;
  logic [LOG2_N-1:0]     samp_cnt;
  logic [BCNT_W-1:0]     blk_cnt;
  logic [4:0]            bpf_log2;

  logic                  accept;
  logic                  last_sample;
  logic                  last_block;
  logic [4:0]            bpf_clamped;
  logic [CSUM_W-1:0]     chan_sum;
  logic [DATA_WIDTH-1:0] pix;
  logic [VAR_W-1:0]      pix_sq;
  logic [DATA_WIDTH-1:0] mean;
  logic [VAR_W-1:0]      mean_sq;
  logic [VAR_W-1:0]      sq_mean;
  logic [VAR_W-1:0]      var_c;
  logic [VAR_W-1:0]      est_c;

`ifdef BLOCK_NOISE_EST_MIN_EN
  logic [VAR_W-1:0]      min_reg;
  logic [VAR_W-1:0]      min_nxt;
`else
  localparam int FACC_W = VAR_W + 16;
  logic [FACC_W-1:0]     frame_acc;
  logic [FACC_W-1:0]     facc_nxt;
`endif

  // The start_of_frame cycle never accepts a pixel, even in ACCUM.
  assign s_ready     = (state == ACCUM) && !start_of_frame;
  assign accept      = s_valid && s_ready;
  assign last_sample = &samp_cnt;
  assign last_block  = (blk_cnt + BCNT_W'(1)) == (BCNT_W'(1) << bpf_log2);
  assign bpf_clamped = (blocks_per_frame_log2 > 5'd16) ? 5'd16 : blocks_per_frame_log2;

  // Channel mean of the incoming pixel and its square.
  always_comb begin
    chan_sum = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      chan_sum = chan_sum + CSUM_W'(s_data[c*DATA_WIDTH +: DATA_WIDTH]);
    end
    pix    = DATA_WIDTH'(chan_sum / CSUM_W'(CHANNELS));
    pix_sq = VAR_W'(pix) * VAR_W'(pix);
  end

  // Block variance: E[p^2] - E[p]^2 with both terms floored, so the difference
  // can go negative by rounding; it is clamped at zero.
  always_comb begin
    mean    = DATA_WIDTH'(sum >> LOG2_N);
    mean_sq = VAR_W'(mean) * VAR_W'(mean);
    sq_mean = VAR_W'(sumsq >> LOG2_N);
    var_c   = (sq_mean >= mean_sq) ? (sq_mean - mean_sq) : '0;
  end

  // Frame reduction including the block currently in FINAL, so the estimate
  // lands in the same cycle as that block's variance.
`ifdef BLOCK_NOISE_EST_MIN_EN
  assign min_nxt = (var_c < min_reg) ? var_c : min_reg;
  assign est_c   = min_nxt;
`else
  assign facc_nxt = frame_acc + FACC_W'(var_c);
  assign est_c    = VAR_W'(facc_nxt >> bpf_log2);
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and process ordering cannot change the result.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: assigning the default first guarantees every path drives
    // state_nxt, so no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = IDLE;
      ACCUM:   if (accept && last_sample) state_nxt = FINAL;
      FINAL:   state_nxt = last_block ? IDLE : ACCUM;
      default: state_nxt = IDLE;
    endcase
    if (start_of_frame) state_nxt = ACCUM;
  end

  // Datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum                   <= '0;
      sumsq                 <= '0;
      samp_cnt              <= '0;
      blk_cnt               <= '0;
      bpf_log2              <= '0;
      block_var             <= '0;
      block_var_valid       <= 1'b0;
      estimated_noise       <= '0;
      estimated_noise_valid <= 1'b0;
`ifdef BLOCK_NOISE_EST_MIN_EN
      min_reg               <= '0;
`else
      frame_acc             <= '0;
`endif
    end else begin
      block_var_valid       <= 1'b0;
      estimated_noise_valid <= 1'b0;
      if (start_of_frame) begin
        // Abort takes priority over a FINAL in the same cycle, so an aborted
        // frame never emits a pulse. Outputs keep their last reported values.
        sum      <= '0;
        sumsq    <= '0;
        samp_cnt <= '0;
        blk_cnt  <= '0;
        bpf_log2 <= bpf_clamped;
`ifdef BLOCK_NOISE_EST_MIN_EN
        min_reg  <= '1;
`else
        frame_acc <= '0;
`endif
      end else begin
        case (state)
          ACCUM: begin
            if (accept) begin
              sum      <= sum + SUM_W'(pix);
              sumsq    <= sumsq + SQ_W'(pix_sq);
              samp_cnt <= samp_cnt + LOG2_N'(1);
            end
          end
          FINAL: begin
            block_var       <= var_c;
            block_var_valid <= 1'b1;
            sum             <= '0;
            sumsq           <= '0;
            samp_cnt        <= '0;
            blk_cnt         <= blk_cnt + BCNT_W'(1);
`ifdef BLOCK_NOISE_EST_MIN_EN
            min_reg         <= min_nxt;
`else
            frame_acc       <= facc_nxt;
`endif
            if (last_block) begin
              estimated_noise       <= est_c;
              estimated_noise_valid <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_block_noise_estimator.sv
// -----------------------------------------------------------------------------
// tb_block_noise_estimator
//
// Directed bench for block_noise_estimator (DATA_WIDTH=8, CHANNELS=3,
// BLOCK_SIZE=8). The driver pushes hand-computed expected block variances and
// frame estimates, tagged with the cycle they must appear in, into scoreboard
// queues. An independent monitor pops and compares on every valid pulse.
// -----------------------------------------------------------------------------
module tb_block_noise_estimator;

  localparam int DW   = 8;
  localparam int CH   = 3;
  localparam int BS   = 8;
  localparam int NPIX = BS * BS;

`ifdef BLOCK_NOISE_EST_MIN_EN
  localparam int EST_MIXED = 0;      // min of {0, 16383, 0, 16383}
`else
  localparam int EST_MIXED = 8191;   // (0 + 16383 + 0 + 16383) / 4, floored
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               start_of_frame;
  logic [4:0]         blocks_per_frame_log2;
  logic [CH*DW-1:0]   s_data;
  logic               s_valid;
  logic               s_ready;
  logic [2*DW-1:0]    block_var;
  logic               block_var_valid;
  logic [2*DW-1:0]    estimated_noise;
  logic               estimated_noise_valid;

  block_noise_estimator #(
    .DATA_WIDTH (DW),
    .CHANNELS   (CH),
    .BLOCK_SIZE (BS)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .start_of_frame        (start_of_frame),
    .blocks_per_frame_log2 (blocks_per_frame_log2),
    .s_data                (s_data),
    .s_valid               (s_valid),
    .s_ready               (s_ready),
    .block_var             (block_var),
    .block_var_valid       (block_var_valid),
    .estimated_noise       (estimated_noise),
    .estimated_noise_valid (estimated_noise_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input longint actual, input longint expected);
    n_total++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
  endtask

  // Scoreboard.
  typedef struct {
    int val;
    int cyc;
  } exp_t;

  exp_t bv_q[$];
  exp_t en_q[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (!rst) begin
      if (block_var_valid) begin
        if (bv_q.size() == 0) check("unexpected block_var_valid", 1, 0);
        else begin
          mon_e = bv_q.pop_front();
          check("block_var", block_var, mon_e.val);
          check("block_var cycle", cyc, mon_e.cyc);
        end
      end
      if (estimated_noise_valid) begin
        if (en_q.size() == 0) check("unexpected estimated_noise_valid", 1, 0);
        else begin
          mon_e = en_q.pop_front();
          check("estimated_noise", estimated_noise, mon_e.val);
          check("estimated_noise cycle", cyc, mon_e.cyc);
        end
      end
    end
  end

  // Driver. Inputs change 1 time unit after the rising edge; the handshake is
  // observed on the falling edge.
  int last_acc;

  function automatic logic [CH*DW-1:0] pixel(input int kind, input int idx);
    logic [DW-1:0] v;
    case (kind)
      0:       return {8'd31, 8'd20, 8'd10};      // channel mean floor(61/3) = 20
      1: begin
        v = idx[0] ? 8'd255 : 8'd0;               // 0/255 alternating
        return {v, v, v};
      end
      default: return '0;
    endcase
  endfunction

  task automatic drive_pixel(input logic [CH*DW-1:0] d, input bit throttle);
    bit done = 1'b0;
    for (int t = 0; t < 64 && !done; t++) begin
      s_data  = d;
      s_valid = throttle ? ($urandom_range(0, 1) == 1) : 1'b1;
      @(negedge clk);
      if (s_valid && s_ready) begin
        done     = 1'b1;
        last_acc = cyc;
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    if (!done) check("pixel accept timeout", 0, 1);
  endtask

  task automatic send_block(input int kind, input bit throttle, input int exp_var,
                            input bit is_last, input int exp_est);
    int first_acc = 0;
    for (int i = 0; i < NPIX; i++) begin
      drive_pixel(pixel(kind, i), throttle);
      if (i == 0) first_acc = last_acc;
    end
    bv_q.push_back('{exp_var, last_acc + 2});
    if (is_last) en_q.push_back('{exp_est, last_acc + 2});
    if (!throttle) check("block throughput", last_acc - first_acc, NPIX - 1);
    @(negedge clk);
    check("s_ready low in FINAL", s_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("s_ready after FINAL", s_ready, is_last ? 0 : 1);
    @(posedge clk); #1;
  endtask

  // A bright pixel is offered during the pulse; it must not be accepted.
  task automatic start_frame(input logic [4:0] l);
    start_of_frame        = 1'b1;
    blocks_per_frame_log2 = l;
    s_valid               = 1'b1;
    s_data                = '1;
    @(negedge clk);
    check("s_ready during start_of_frame", s_ready, 0);
    @(posedge clk); #1;
    start_of_frame = 1'b0;
    s_valid        = 1'b0;
    @(negedge clk);
    check("s_ready after start_of_frame", s_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic mixed_frame(input bit throttle);
    start_frame(5'd2);
    send_block(2, throttle, 0,     1'b0, 0);
    send_block(1, throttle, 16383, 1'b0, 0);
    send_block(0, throttle, 0,     1'b0, 0);
    send_block(1, throttle, 16383, 1'b1, EST_MIXED);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst                   = 1'b1;
    start_of_frame        = 1'b0;
    blocks_per_frame_log2 = '0;
    s_data                = '0;
    s_valid               = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset s_ready", s_ready, 0);
    check("reset block_var", block_var, 0);
    check("reset block_var_valid", block_var_valid, 0);
    check("reset estimated_noise", estimated_noise, 0);
    check("reset estimated_noise_valid", estimated_noise_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Constant block: every pixel averages to 20, variance 0.
    start_frame(5'd0);
    send_block(0, 1'b0, 0, 1'b1, 0);

    // Checkerboard: mean 127, E[p^2] 32512, variance 16383.
    start_frame(5'd0);
    send_block(1, 1'b0, 16383, 1'b1, 16383);

    // Asynchronous reset in the middle of a block.
    start_frame(5'd2);
    for (int i = 0; i < 10; i++) drive_pixel(pixel(1, i), 1'b0);
    #1 rst = 1'b1;
    #1;
    check("async reset s_ready", s_ready, 0);
    check("async reset block_var", block_var, 0);
    check("async reset block_var_valid", block_var_valid, 0);
    check("async reset estimated_noise", estimated_noise, 0);
    check("async reset estimated_noise_valid", estimated_noise_valid, 0);
    @(posedge clk); #1;
    rst     = 1'b0;
    s_valid = 1'b1;
    s_data  = pixel(1, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle after reset", s_ready, 0);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;

    // Four-block frame, then the same frame with a 50% duty s_valid.
    mixed_frame(1'b0);
    mixed_frame(1'b1);

    // Abort after two full blocks plus five pixels, then a full frame.
    start_frame(5'd2);
    send_block(1, 1'b0, 16383, 1'b0, 0);
    send_block(1, 1'b0, 16383, 1'b0, 0);
    for (int i = 0; i < 5; i++) drive_pixel(pixel(1, i), 1'b0);
    mixed_frame(1'b0);

    for (int t = 0; t < 20 && (bv_q.size() + en_q.size()) != 0; t++) @(posedge clk);
    check("scoreboard drained", bv_q.size() + en_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/block_noise_estimator.md
# block_noise_estimator

Streaming per-block noise estimator that replaces the clock-gated noise_estimation + RGB_mean pair in the memory-slave → noise-estimation path. It accepts packed multi-channel pixels over a valid/ready handshake, averages channels per pixel, and computes the variance of each BLOCK_SIZE×BLOCK_SIZE block. It then reduces all block variances of a frame to one noise estimate for the Wiener stage. Block size, channel count and pixel width are parametrised, and the reduction mode is compile-time selectable.

## Interface
- DATA_WIDTH, 8, bits per channel sample
- CHANNELS, 3, channels packed per input word, channel 0 in LSBs
- BLOCK_SIZE, 8, block edge; power of 2, 2..16
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- start_of_frame  in  1  one-cycle pulse; clears all state and arms a new frame
- blocks_per_frame_log2  in  5  log2 of blocks per frame; sampled at start_of_frame; values >16 clamp to 16
- s_data  in  CHANNELS*DATA_WIDTH  packed pixel
- s_valid  in  1  pixel valid
- s_ready  out  1  pixel accepted when s_valid && s_ready
- block_var  out  2*DATA_WIDTH  variance of last completed block
- block_var_valid  out  1  one-cycle pulse
- estimated_noise  out  2*DATA_WIDTH  frame estimate, held until next update
- estimated_noise_valid  out  1  one-cycle pulse

## Operation
- States: IDLE, ACCUM, FINAL.
- IDLE: s_ready=0. start_of_frame → ACCUM.
- ACCUM: s_ready=1. Each accepted pixel p = floor(sum of CHANNELS channels / CHANNELS), width DATA_WIDTH. It accumulates sum += p and sumsq += p². The sample counter counts 0..BLOCK_SIZE²−1. On the last sample of a block → FINAL.
- FINAL: s_ready=0 for exactly one cycle. Computes N=BLOCK_SIZE², mean=sum>>log2(N), var=(sumsq>>log2(N))−mean², saturated at 0. It clears sum, sumsq and the sample counter, and increments the block counter. → ACCUM, or → IDLE when block count reaches 2^blocks_per_frame_log2.
- Accumulator widths: sum DATA_WIDTH+2·log2(BLOCK_SIZE), sumsq 2·DATA_WIDTH+2·log2(BLOCK_SIZE); no overflow is possible.
- Frame reduction (default): frame_acc (2·DATA_WIDTH+16 bits) += var; estimate = frame_acc>>blocks_per_frame_log2 (floor).
- start_of_frame in any state: abort, clear counters and accumulators, → ACCUM. An aborted frame produces no valid pulses. A pixel offered in the start_of_frame cycle is not accepted.
- Pixels are raster-ordered within a block. Block ordering is the reader's responsibility.

## Timing
- Reset values: s_ready=0, block_var=0, block_var_valid=0, estimated_noise=0, estimated_noise_valid=0, state IDLE, all counters and accumulators 0.
- start_of_frame high in cycle t → s_ready=1 in cycle t+1.
- Last block sample accepted in cycle k → FINAL in cycle k+1 (s_ready=0) → block_var_valid=1 and block_var updated in cycle k+2.
- On the last block of a frame, estimated_noise_valid and estimated_noise update in cycle k+2, the same cycle as that block's block_var_valid. The state is IDLE from k+2.
- Sustained throughput: BLOCK_SIZE² pixels per BLOCK_SIZE²+1 cycles.
- s_valid may toggle freely. Only the handshake advances the counters.

## Configuration
- BLOCK_NOISE_EST_MIN_EN defined: the frame reduction is the minimum block variance. min_reg is initialised to all-ones at start_of_frame, and estimated_noise = final min_reg. frame_acc is not built.
- Undefined: the frame reduction is the mean of the block variances (as in Operation).

## Test plan
- Reset mid-ACCUM: assert rst after 10 pixels → all outputs 0 and s_ready=0 immediately (asynchronous); after release, nothing happens until start_of_frame.
- Channel mean, constant block: CHANNELS=3, every pixel (10,20,31), log2=0 → p=20, block_var=0, estimated_noise=0, valid in cycle k+2.
- Checkerboard: all channels equal, alternating 0/255 over 64 pixels, log2=0 → mean=127, sumsq>>6=32512, block_var=16383, estimated_noise=16383.
- Mean reduction: log2=2, blocks of variance 0, 16383, 0, 16383 → four block_var_valid pulses, estimated_noise=8191. Same input with BLOCK_NOISE_EST_MIN_EN → 0.
- Throttled input: s_valid random at 50% → identical results. s_ready is low exactly one cycle per block, and no pixel is dropped or double-counted.
- Abort: start_of_frame after 2 of 4 blocks, then a full 4-block frame → no estimated_noise_valid for the first frame, and a correct estimate for the second.
